// File: rtl/boot_pkg.sv
`default_nettype none
// ============================================================================
// Module   : boot_pkg
// Brief    : Shared state codes, error codes and defaults for the boot loader.
// Revision : 1.0
// ============================================================================
package boot_pkg;

  localparam int DEPTH_DEFAULT = 1024;

  typedef logic [2:0] state_t;
  localparam state_t ST_LEN_HI = 3'd0;
  localparam state_t ST_LEN_LO = 3'd1;
  localparam state_t ST_DAT_HI = 3'd2;
  localparam state_t ST_DAT_LO = 3'd3;
  localparam state_t ST_CHK_HI = 3'd4;
  localparam state_t ST_CHK_LO = 3'd5;
  localparam state_t ST_RUN    = 3'd6;
  localparam state_t ST_ERROR  = 3'd7;

  typedef logic [1:0] err_t;
  localparam err_t ERR_NONE = 2'd0;
  localparam err_t ERR_LEN  = 2'd1;
  localparam err_t ERR_CHK  = 2'd2;

  // Every state except the two terminal ones is still consuming the stream.
  function automatic logic is_loading(input state_t s);
    return (s != ST_RUN) && (s != ST_ERROR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/byte_pair_assembler.sv
`default_nettype none
// ============================================================================
// Module   : byte_pair_assembler
// Brief    : Latches a high byte and presents {hi, lo} as a word on lo accept.
// Revision : 1.0
// ============================================================================
module byte_pair_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_hi_we,
  input  logic        i_lo_we,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [15:0] o_word
);

  logic [7:0] r_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= 8'h00;
    end else if (i_hi_we) begin
      r_hi <= i_byte;
    end
  end

  // The word is valid in the lo-accept cycle so the loader can act on it
  // at the same edge, keeping back-to-back words stall-free.
  assign o_word_valid = i_lo_we;
  assign o_word       = {r_hi, i_byte};

endmodule
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader
// Brief    : Loads a length-prefixed, checksummed byte image into instruction
//            memory while holding the CPU in reset, then releases it.
// Revision : 1.0
// ============================================================================
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int DEPTH  = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err
);

  state_t              r_state;
  err_t                r_err;
  logic [15:0]         r_len;
  logic [15:0]         r_sum;
  logic [ADDR_W-1:0]   r_idx;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  logic                w_rx_en;
  logic                w_acc;
  logic                w_hi_we;
  logic                w_lo_we;
  logic                w_word_valid;
  logic [15:0]         w_word;
  logic                w_last;

  // load_req masks ready so a byte offered alongside it is never consumed.
  assign w_rx_en = is_loading(r_state) && !load_req;
  assign w_acc   = rx_valid && w_rx_en;
  assign w_hi_we = w_acc && ((r_state == ST_LEN_HI) || (r_state == ST_DAT_HI) ||
                             (r_state == ST_CHK_HI));
  assign w_lo_we = w_acc && ((r_state == ST_LEN_LO) || (r_state == ST_DAT_LO) ||
                             (r_state == ST_CHK_LO));
  assign w_last  = (16'(r_idx) == (r_len - 16'd1));

  byte_pair_assembler u_pair (
    .clk          (clk),
    .rst_n        (rst),
    .i_hi_we      (w_hi_we),
    .i_lo_we      (w_lo_we),
    .i_byte       (rx_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_LEN_HI;
      r_err   <= ERR_NONE;
      r_len   <= 16'h0000;
      r_sum   <= 16'h0000;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= 1'b0;
      if (load_req) begin
        r_state <= ST_LEN_HI;
        r_err   <= ERR_NONE;
        r_sum   <= 16'h0000;
        r_idx   <= '0;
      end else if (w_acc) begin
        case (r_state)
          ST_LEN_HI: r_state <= ST_LEN_LO;
          ST_LEN_LO: begin
            r_len <= w_word;
            r_idx <= '0;
            if (w_word > 16'(DEPTH)) begin
              r_state <= ST_ERROR;
              r_err   <= ERR_LEN;
            end else if (w_word == 16'h0000) begin
              r_state <= ST_CHK_HI;
            end else begin
              r_state <= ST_DAT_HI;
            end
          end
          ST_DAT_HI: r_state <= ST_DAT_LO;
          ST_DAT_LO: begin
            r_we    <= w_word_valid;
            r_addr  <= r_idx;
            r_wdata <= DATA_W'(w_word);
            r_sum   <= r_sum + w_word;
            r_idx   <= r_idx + 1'b1;
            r_state <= w_last ? ST_CHK_HI : ST_DAT_HI;
          end
          ST_CHK_HI: r_state <= ST_CHK_LO;
          ST_CHK_LO: begin
            if (w_word == r_sum) begin
              r_state <= ST_RUN;
            end else begin
              r_state <= ST_ERROR;
              r_err   <= ERR_CHK;
            end
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

  assign rx_ready   = w_rx_en;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign busy       = is_loading(r_state);
  assign done       = (r_state == ST_RUN);
  assign cpu_rst    = (r_state == ST_RUN);
  assign err        = r_err;

endmodule
`default_nettype wire

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot sequencer for the 16-bit accumulator CPU. Receives a byte stream over a valid/ready handshake, assembles 16-bit instruction words, and writes them into the 1024-word instruction memory.
- Holds the CPU in reset while loading. Checks a 16-bit additive checksum, then releases the CPU.
- Sits between the host byte link (UART/SPI front end) and the instruction memory write port / CPU reset pin.

Parameters:
- ADDR_W, 10, instruction memory address width
- DATA_W, 16, instruction word width
- DEPTH, 1024, maximum word count accepted (must be <= 2**ADDR_W)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- load_req  in  1  level; restart the load sequence
- rx_data  in  8  stream byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts byte
- imem_we  out  1  instruction memory write strobe
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  DATA_W  write data
- cpu_rst  out  1  active-low reset to CPU; 0 holds the CPU
- busy  out  1  load in progress
- done  out  1  image loaded and verified; CPU running
- err  out  2  0 none, 1 length error, 2 checksum error

Behaviour:
- Reset (rst=0, async): state LEN_HI. Counters and sum cleared. Outputs: rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=0, busy=1, done=0, err=0.
- Byte acceptance: a byte is accepted on a rising clk edge with rx_valid&&rx_ready. rx_ready is 1 in LEN_HI, LEN_LO, DAT_HI, DAT_LO, CHK_HI, CHK_LO, and 0 in RUN and ERROR. rx_ready has no combinational path from rx_valid.
- Stream format: all fields are big-endian. N[15:8], N[7:0], then N words (hi byte, lo byte), then checksum hi, checksum lo.
- LEN_HI -> LEN_LO on accept.
- LEN_LO on accept:
  - N > DEPTH -> ERROR, err=1.
  - N == 0 -> CHK_HI.
  - Otherwise -> DAT_HI, word index=0.
- DAT_HI -> DAT_LO on accept; the hi byte is latched.
- DAT_LO on accept, in the next cycle:
  - imem_we=1 for exactly one cycle, imem_addr=index, imem_wdata={hi,lo}.
  - sum <= sum + word (mod 2**16).
  - index increments.
  - Next state is DAT_HI, or CHK_HI once N words have been taken.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- The minimum byte spacing is one cycle; back-to-back words must be sustained with no extra stall.
- CHK_HI -> CHK_LO on accept. In CHK_LO on accept, compare {hi,lo} with the final sum, including the last word's contribution:
  - Match -> RUN. Next cycle: cpu_rst=1, done=1, busy=0.
  - Mismatch -> ERROR, err=2.
- ERROR: busy=0, done=0, cpu_rst=0, err held.
- RUN: stream input is ignored.
- load_req=1 in any state: next cycle → LEN_HI, cpu_rst=0, busy=1, done=0, err=0, sum=0, index=0, rx_ready=1.
  - A byte handshake in the same cycle is dropped.
  - While load_req stays high, the loader stays in LEN_HI and does not accept bytes (rx_ready=0).
- After async reset the loader starts loading immediately; no load_req is required.
- Wrap-around: the sum wraps modulo 2**16. The index never exceeds DEPTH-1 because of the length check.

Decomposition:
- Package boot_pkg holds:
  - state enum: LEN_HI, LEN_LO, DAT_HI, DAT_LO, CHK_HI, CHK_LO, RUN, ERROR
  - error codes ERR_NONE=0, ERR_LEN=1, ERR_CHK=2
  - DEPTH default
- Sub-module byte_pair_assembler: latches the hi byte and produces a one-cycle word_valid with a 16-bit word on lo-byte accept. It is reused for length, data and checksum.
- The FSM, counters and sum stay in imem_boot_loader.

Test Plan:
- Normal load:
  - Stimulus: after reset, stream 00 03 12 34 AB CD 00 01 BE 02.
  - Response: writes 0x1234@0, 0xABCD@1, 0x0001@2, one strobe each; then done=1, cpu_rst=1, busy=0, err=0.
- Bad checksum:
  - Stimulus: same stream, checksum BE 03.
  - Response: three writes, then err=2, cpu_rst=0, done=0, rx_ready=0.
- Oversize length:
  - Stimulus: header 04 01 (1025).
  - Response: err=1 the cycle after the lo byte; no imem_we ever; rx_ready=0.
- Empty image and sum wrap:
  - Stimulus A: 00 00 00 00.
  - Response A: done with no writes.
  - Stimulus B: 00 02 FF FF 00 02 00 01, with random rx_valid gaps.
  - Response B: pass, sum wrapped to 0x0001.
- Reload:
  - Stimulus: in RUN, pulse load_req for one cycle.
  - Response: cpu_rst=0 next cycle, busy=1. A second image loads and overwrites from addr 0.
  - Also: a byte offered in the load_req cycle is not consumed.
- Async reset mid-load:
  - Stimulus: assert rst=0 during DAT_LO between edges.
  - Response: outputs go to reset values immediately, without a clk edge.
  - After release, a full image loads correctly.
